// File: rtl/fetch_unit.sv
// Instruction fetch: PC, req/ack word reads, registered Instr with Op/Func; request-to-InstrValid = mem latency + 1.
// Stall freezes outputs, one-entry skid catches a word acked under Stall; PCSrc redirects and squashes the wrong path.
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [31:0]       IMemData,
    input  logic              Stall,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [31:0]       Instr,
    output logic [5:0]        Op,
    output logic [5:0]        Func,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              InstrValid,
    output logic              AddrErr
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc4;
    logic              r_vld;
    logic [31:0]       r_skid;
    logic [ADDR_W-1:0] r_skid_pc4;
    logic              r_err;

    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_pc4;
    logic              w_misalign;

    assign w_tgt      = {BranchTarget[ADDR_W-1:2], 2'b00};
    assign w_misalign = |BranchTarget[1:0];
    assign w_pc4      = r_pc + ADDR_W'(4);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_instr    <= '0;
            r_pc4      <= '0;
            r_vld      <= 1'b0;
            r_skid     <= '0;
            r_skid_pc4 <= '0;
            r_err      <= 1'b0;
        end else if (PCSrc) begin
            r_pc  <= w_tgt;
            r_err <= r_err | w_misalign;
            r_vld <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    // An unacked request cannot be withdrawn: keep its address and drain it.
                    if (r_req && !IMemAck) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= w_tgt;
                        r_req  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_FETCH;
                    r_addr  <= w_tgt;
                    r_req   <= 1'b1;
                end
                S_DRAIN: begin
                    if (IMemAck) begin
                        r_state <= S_FETCH;
                        r_addr  <= w_tgt;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= r_pc;
                    end else if (IMemAck) begin
                        r_pc <= w_pc4;
                        if (Stall) begin
                            r_skid     <= IMemData;
                            r_skid_pc4 <= w_pc4;
                            r_req      <= 1'b0;
                            r_state    <= S_HOLD;
                        end else begin
                            r_instr <= IMemData;
                            r_pc4   <= w_pc4;
                            r_vld   <= 1'b1;
                            r_addr  <= w_pc4;
                        end
                    end else if (!Stall) begin
                        r_vld <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        r_instr <= r_skid;
                        r_pc4   <= r_skid_pc4;
                        r_vld   <= 1'b1;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Wrong-path data is dropped; the real path resumes from the redirected PC.
                    if (IMemAck) begin
                        r_addr  <= r_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign IMemReq    = r_req;
    assign IMemAddr   = r_addr;
    assign Instr      = r_instr;
    assign Op         = r_instr[31:26];
    assign Func       = r_instr[5:0];
    assign PCPlus4    = r_pc4;
    assign InstrValid = r_vld;
    assign AddrErr    = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan steps then random memory latency/stall/redirect traffic vs a transaction-level model.
module tb_fetch_unit;

    logic        Clk;
    logic        Rst;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [5:0]  Func;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        AddrErr;

    logic        Rst_h;
    logic        req_h;
    logic [31:0] addr_h;
    logic        ack_h;
    logic [31:0] data_h;
    logic        pcsrc_h;
    logic [31:0] tgt_h;
    logic [31:0] instr_h;
    logic [5:0]  op_h;
    logic [5:0]  func_h;
    logic [31:0] pc4_h;
    logic        vld_h;
    logic        err_h;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .Clk(Clk), .Rst(Rst), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemAck(IMemAck), .IMemData(IMemData), .Stall(Stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .Instr(Instr), .Op(Op), .Func(Func),
        .PCPlus4(PCPlus4), .InstrValid(InstrValid), .AddrErr(AddrErr)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_h (
        .Clk(Clk), .Rst(Rst_h), .IMemReq(req_h), .IMemAddr(addr_h),
        .IMemAck(ack_h), .IMemData(data_h), .Stall(1'b0), .PCSrc(pcsrc_h),
        .BranchTarget(tgt_h), .Instr(instr_h), .Op(op_h), .Func(func_h),
        .PCPlus4(pc4_h), .InstrValid(vld_h), .AddrErr(err_h)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: one outstanding request, a queue of words fetched but not yet handed on.
    typedef struct {
        logic [31:0] d;
        logic [31:0] p4;
    } word_t;

    word_t       m_q[$];
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic        m_wrong;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_vld;
    logic        m_err;

    task automatic model_reset();
        m_q.delete();
        m_req   = 1'b0;
        m_addr  = 32'h0;
        m_pc    = 32'h0;
        m_wrong = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_vld   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic ack, input logic [31:0] data, input logic stall,
                              input logic pcsrc, input logic [31:0] tgt);
        word_t w;
        logic  accepted;
        accepted = m_req && ack;
        if (pcsrc) begin
            m_err = m_err || (tgt % 4 != 0);
            m_vld = 1'b0;
            m_q.delete();
            m_pc  = tgt - (tgt % 4);
            if (m_req && !ack) begin
                m_wrong = 1'b1;
            end else begin
                m_req   = 1'b1;
                m_addr  = m_pc;
                m_wrong = 1'b0;
            end
        end else if (accepted && m_wrong) begin
            m_wrong = 1'b0;
            m_addr  = m_pc;
        end else if (accepted) begin
            w.d  = data;
            w.p4 = m_addr + 32'd4;
            m_pc = w.p4;
            if (stall) begin
                m_q.push_back(w);
                m_req = 1'b0;
            end else begin
                m_instr = w.d;
                m_pc4   = w.p4;
                m_vld   = 1'b1;
                m_addr  = m_pc;
            end
        end else if (m_q.size() > 0) begin
            if (!stall) begin
                w       = m_q.pop_front();
                m_instr = w.d;
                m_pc4   = w.p4;
                m_vld   = 1'b1;
                m_req   = 1'b1;
                m_addr  = m_pc;
            end
        end else if (!m_req) begin
            m_req  = 1'b1;
            m_addr = m_pc;
        end else if (!stall) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".req"}, 32'(IMemReq), 32'(m_req));
        if (m_req) chk({tag, ".addr"}, IMemAddr, m_addr);
        chk({tag, ".instr"}, Instr, m_instr);
        chk({tag, ".op"}, 32'(Op), 32'(m_instr[31:26]));
        chk({tag, ".func"}, 32'(Func), 32'(m_instr[5:0]));
        chk({tag, ".pc4"}, PCPlus4, m_pc4);
        chk({tag, ".vld"}, 32'(InstrValid), 32'(m_vld));
        chk({tag, ".err"}, 32'(AddrErr), 32'(m_err));
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
    task automatic cyc(input string tag, input logic ack, input logic [31:0] data, input logic stall,
                       input logic pcsrc, input logic [31:0] tgt);
        IMemAck      = ack;
        IMemData     = data;
        Stall        = stall;
        PCSrc        = pcsrc;
        BranchTarget = tgt;
        model_step(ack, data, stall, pcsrc, tgt);
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    int          lat;
    int          cnt;
    logic        r_ack;
    logic        r_stall;
    logic        r_pcsrc;
    logic [31:0] r_tgt;

    initial begin
        Rst = 1'b0; IMemAck = 1'b0; IMemData = '0; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
        Rst_h = 1'b0; ack_h = 1'b0; data_h = '0; pcsrc_h = 1'b0; tgt_h = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        compare_all("reset");
        chk("reset.addr", IMemAddr, 32'h0);
        Rst = 1'b1;

        // Same-cycle acks: one instruction per cycle.
        cyc("p1.rise", 0, 32'h0, 0, 0, 32'h0);
        chk("p1.addr0", IMemAddr, 32'h0);
        cyc("p1.w0", 1, 32'h0000_0020, 0, 0, 32'h0);
        chk("p1.addr4", IMemAddr, 32'h4);
        chk("p1.func0", 32'(Func), 32'h20);
        cyc("p1.w1", 1, 32'h0000_0022, 0, 0, 32'h0);
        chk("p1.pc4_8", PCPlus4, 32'h8);
        cyc("p1.w2", 1, 32'h2008_0005, 0, 0, 32'h0);
        chk("p1.op2", 32'(Op), 32'h08);
        chk("p1.func2", 32'(Func), 32'h05);
        chk("p1.pc4_12", PCPlus4, 32'd12);

        // Three-cycle memory latency on address 12.
        cyc("p2.c1", 0, 32'h0, 0, 0, 32'h0);
        chk("p2.vld_low", 32'(InstrValid), 32'h0);
        cyc("p2.c2", 0, 32'h0, 0, 0, 32'h0);
        chk("p2.addr_hold", IMemAddr, 32'd12);
        cyc("p2.ack", 1, 32'h1111_0001, 0, 0, 32'h0);
        chk("p2.instr", Instr, 32'h1111_0001);

        // Stall on the ack for address 16: word parks in the skid.
        cyc("p3.stall_ack", 1, 32'h2222_0002, 1, 0, 32'h0);
        chk("p3.req_low", 32'(IMemReq), 32'h0);
        chk("p3.old_instr", Instr, 32'h1111_0001);
        cyc("p3.stall2", 0, 32'h0, 1, 0, 32'h0);
        cyc("p3.release", 0, 32'h0, 0, 0, 32'h0);
        chk("p3.skid_instr", Instr, 32'h2222_0002);
        chk("p3.next_addr", IMemAddr, 32'd20);

        // Redirect while a request to 20 is outstanding.
        cyc("p4.wait", 0, 32'h0, 0, 0, 32'h0);
        cyc("p4.redir", 0, 32'h0, 0, 1, 32'h40);
        chk("p4.drain_addr", IMemAddr, 32'd20);
        cyc("p4.drain_ack", 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        chk("p4.new_addr", IMemAddr, 32'h40);
        chk("p4.squashed", Instr, 32'h2222_0002);
        cyc("p4.wait2", 0, 32'h0, 0, 0, 32'h0);
        cyc("p4.ack", 1, 32'h3333_0003, 0, 0, 32'h0);
        chk("p4.pc4", PCPlus4, 32'h44);

        // Redirect out of HOLD under Stall to a misaligned target.
        cyc("p5.hold", 1, 32'h4444_0004, 1, 0, 32'h0);
        cyc("p5.redir", 0, 32'h0, 1, 1, 32'h42);
        chk("p5.vld", 32'(InstrValid), 32'h0);
        chk("p5.addr", IMemAddr, 32'h40);
        chk("p5.err", 32'(AddrErr), 32'h1);
        cyc("p5.stalled", 0, 32'h0, 1, 0, 32'h0);
        cyc("p5.ack", 1, 32'h5555_0005, 0, 0, 32'h0);
        chk("p5.err_sticky", 32'(AddrErr), 32'h1);

        // Random traffic with a memory of 1..4 cycle latency.
        lat = 0;
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                Rst = 1'b0;
                #1;
                model_reset();
                compare_all("rnd.arst");
                @(posedge Clk);
                #1;
                Rst = 1'b1;
                cnt = 0;
            end
            r_ack = 1'b0;
            if (IMemReq) begin
                if (cnt >= lat) begin
                    r_ack = 1'b1;
                    cnt   = 0;
                    lat   = $urandom_range(0, 3);
                end else begin
                    cnt++;
                end
            end
            r_stall = ($urandom_range(0, 9) < 3);
            r_pcsrc = ($urandom_range(0, 19) == 0);
            r_tgt   = {16'h0, $urandom_range(0, 16'hFFFF)};
            if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
            cyc("rnd", r_ack, $urandom, r_stall, r_pcsrc, r_tgt);
        end

        // Wrap-around reset PC, reset asserted mid-drain.
        Rst_h = 1'b1;
        @(posedge Clk);
        #1;
        chk("p6.first_addr", addr_h, 32'hFFFF_FFFC);
        pcsrc_h = 1'b1;
        tgt_h   = 32'h100;
        @(posedge Clk);
        #1;
        pcsrc_h = 1'b0;
        chk("p6.drain_addr", addr_h, 32'hFFFF_FFFC);
        Rst_h = 1'b0;
        #1;
        chk("p6.rst_req", 32'(req_h), 32'h0);
        chk("p6.rst_instr", instr_h, 32'h0);
        chk("p6.rst_pc4", pc4_h, 32'h0);
        chk("p6.rst_vld", 32'(vld_h), 32'h0);
        chk("p6.rst_err", 32'(err_h), 32'h0);
        @(posedge Clk);
        #1;
        Rst_h = 1'b1;
        @(posedge Clk);
        #1;
        chk("p6.req", 32'(req_h), 32'h1);
        chk("p6.addr", addr_h, 32'hFFFF_FFFC);
        ack_h  = 1'b1;
        data_h = 32'h0000_1234;
        @(posedge Clk);
        #1;
        ack_h = 1'b0;
        chk("p6.pc4_wrap", pc4_h, 32'h0);
        chk("p6.instr", instr_h, 32'h0000_1234);
        chk("p6.vld", 32'(vld_h), 32'h1);
        chk("p6.next_addr", addr_h, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
